// File: rtl/exu_redirect_ctrl.sv
// Execute-stage redirect sequencer: arbitrates int/exc/bru redirect requests,
// hands the winning target to the IFU, then drives a fixed-length pipeline flush.
module exu_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_req_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  input  logic              exc_req_i,
  input  logic [ADDR_W-1:0] exc_addr_i,
  input  logic              bru_req_i,
  input  logic [ADDR_W-1:0] bru_addr_i,
  output logic              int_ack_o,
  output logic              exc_ack_o,
  output logic              bru_ack_o,
  output logic              redir_valid_o,
  output logic [ADDR_W-1:0] redir_addr_o,
  output logic [1:0]        redir_src_o,
  input  logic              ifu_ready_i,
  output logic              flush_o,
  output logic              hold_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BRU  = 2'd1;
  localparam logic [1:0] SRC_EXC  = 2'd2;
  localparam logic [1:0] SRC_INT  = 2'd3;
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        src_q, src_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    src_d     = src_q;
    int_ack_o = 1'b0;
    exc_ack_o = 1'b0;
    bru_ack_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Fixed priority int > exc > bru; losers keep their request asserted.
        if (int_req_i) begin
          int_ack_o = 1'b1;
          addr_d    = {int_addr_i[ADDR_W-1:1], 1'b0};
          src_d     = SRC_INT;
          state_d   = S_REDIR;
        end else if (exc_req_i) begin
          exc_ack_o = 1'b1;
          addr_d    = {exc_addr_i[ADDR_W-1:1], 1'b0};
          src_d     = SRC_EXC;
          state_d   = S_REDIR;
        end else if (bru_req_i) begin
          bru_ack_o = 1'b1;
          addr_d    = {bru_addr_i[ADDR_W-1:1], 1'b0};
          src_d     = SRC_BRU;
          state_d   = S_REDIR;
        end
      end
      S_REDIR: begin
        if (ifu_ready_i) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LAST;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          src_d   = SRC_NONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        src_d   = SRC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
    end
  end

  // Target and source are only presented while a redirect is actually pending.
  assign redir_valid_o = (state_q == S_REDIR);
  assign redir_addr_o  = redir_valid_o ? addr_q : '0;
  assign redir_src_o   = redir_valid_o ? src_q : SRC_NONE;
  assign flush_o       = (state_q == S_FLUSH);
  assign hold_o        = (state_q != S_IDLE) | int_req_i | exc_req_i | bru_req_i;

endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// Self-checking bench for exu_redirect_ctrl: scoreboard of expected redirects
// popped on each IFU handshake, plus flush-length checks for FLUSH_CYCLES 1/2/15.
module tb_exu_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        int_req, exc_req, bru_req, ifu_ready;
  logic [31:0] int_addr, exc_addr, bru_addr;
  logic        int_ack, exc_ack, bru_ack;
  logic        redir_valid, flush, hold;
  logic [31:0] redir_addr;
  logic [1:0]  redir_src;

  // Shared stimulus for the FLUSH_CYCLES=1 and =15 instances.
  logic        breq_f, ready_f;
  logic [31:0] baddr_f;
  logic        ack1_int, ack1_exc, ack1_bru, val1, flush1, hold1;
  logic        ack15_int, ack15_exc, ack15_bru, val15, flush15, hold15;
  logic [31:0] addr1, addr15;
  logic [1:0]  src1, src15;

  int checks;
  int failures;
  logic [33:0] sb_q[$];
  logic [33:0] sb_e;

  exu_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .int_req_i(int_req), .int_addr_i(int_addr),
    .exc_req_i(exc_req), .exc_addr_i(exc_addr),
    .bru_req_i(bru_req), .bru_addr_i(bru_addr),
    .int_ack_o(int_ack), .exc_ack_o(exc_ack), .bru_ack_o(bru_ack),
    .redir_valid_o(redir_valid), .redir_addr_o(redir_addr), .redir_src_o(redir_src),
    .ifu_ready_i(ifu_ready), .flush_o(flush), .hold_o(hold)
  );

  exu_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(1)) dut_f1 (
    .clk(clk), .rst_n(rst_n),
    .int_req_i(1'b0), .int_addr_i(32'h0),
    .exc_req_i(1'b0), .exc_addr_i(32'h0),
    .bru_req_i(breq_f), .bru_addr_i(baddr_f),
    .int_ack_o(ack1_int), .exc_ack_o(ack1_exc), .bru_ack_o(ack1_bru),
    .redir_valid_o(val1), .redir_addr_o(addr1), .redir_src_o(src1),
    .ifu_ready_i(ready_f), .flush_o(flush1), .hold_o(hold1)
  );

  exu_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(15)) dut_f15 (
    .clk(clk), .rst_n(rst_n),
    .int_req_i(1'b0), .int_addr_i(32'h0),
    .exc_req_i(1'b0), .exc_addr_i(32'h0),
    .bru_req_i(breq_f), .bru_addr_i(baddr_f),
    .int_ack_o(ack15_int), .exc_ack_o(ack15_exc), .bru_ack_o(ack15_bru),
    .redir_valid_o(val15), .redir_addr_o(addr15), .redir_src_o(src15),
    .ifu_ready_i(ready_f), .flush_o(flush15), .hold_o(hold15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts the flush window that follows a handshake; acks must stay low inside it.
  task automatic count_flush(input int exp_n, input string tag);
    int   n;
    bit   seen;
    logic ack_seen;
    n = 0;
    seen = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      #1;
      if (flush) begin
        n++;
        seen = 1'b1;
        ack_seen = ack_seen | int_ack | exc_ack | bru_ack;
      end else if (seen) begin
        break;
      end
    end
    check_val(tag, n, exp_n);
    check_val({tag, "_acks"}, {31'b0, ack_seen}, 32'd0);
  endtask

  function automatic logic [31:0] acks();
    return {29'b0, int_ack, exc_ack, bru_ack};
  endfunction

  // Scoreboard: every IFU handshake must match the oldest expected redirect.
  always @(negedge clk) begin
    if (rst_n && redir_valid && ifu_ready) begin
      check_val("sb_pending", {31'b0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check_val("sb_addr", redir_addr, sb_e[31:0]);
        check_val("sb_src", {30'b0, redir_src}, {30'b0, sb_e[33:32]});
        $display("redirect src=%0d addr=0x%08h", redir_src, redir_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  n1, n15;
    bit  d1, d15;
    logic f_acks;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    {int_req, exc_req, bru_req, ifu_ready} = '0;
    int_addr = '0; exc_addr = '0; bru_addr = '0;
    breq_f = 1'b0; ready_f = 1'b1; baddr_f = '0;
    repeat (3) cyc();
    #1;
    check_val("rst_valid", {31'b0, redir_valid}, 0);
    check_val("rst_addr", redir_addr, 0);
    check_val("rst_src", {30'b0, redir_src}, 0);
    check_val("rst_flush_hold", {30'b0, flush, hold}, 0);
    check_val("rst_acks", acks(), 0);
    rst_n = 1'b1;

    // Single branch, bit 0 of the target is dropped
    cyc();
    bru_req = 1'b1; bru_addr = 32'h0000_1235; ifu_ready = 1'b1;
    #1;
    check_val("t1_ack", acks(), 32'b001);
    check_val("t1_hold", {31'b0, hold}, 1);
    sb_q.push_back({2'd1, 32'h0000_1234});
    cyc();
    bru_req = 1'b0;
    #1;
    check_val("t1_valid", {31'b0, redir_valid}, 1);
    check_val("t1_addr", redir_addr, 32'h0000_1234);
    check_val("t1_src", {30'b0, redir_src}, 1);
    check_val("t1_redir_flush", {31'b0, flush}, 0);
    count_flush(2, "t1_flush");
    check_val("t1_idle_hold", {31'b0, hold}, 0);
    check_val("t1_idle_valid", {31'b0, redir_valid}, 0);

    // Priority: int wins, exc held and taken on IDLE re-entry
    int_req = 1'b1; int_addr = 32'h8000_0100;
    exc_req = 1'b1; exc_addr = 32'h8000_0200;
    bru_req = 1'b1; bru_addr = 32'h0000_0100;
    #1;
    check_val("t2_ack", acks(), 32'b100);
    sb_q.push_back({2'd3, 32'h8000_0100});
    cyc();
    int_req = 1'b0; bru_req = 1'b0;
    #1;
    check_val("t2_addr", redir_addr, 32'h8000_0100);
    check_val("t2_src", {30'b0, redir_src}, 3);
    check_val("t2_redir_ack", acks(), 0);
    count_flush(2, "t2_flush");
    check_val("t2_exc_ack", acks(), 32'b010);
    sb_q.push_back({2'd2, 32'h8000_0200});
    cyc();
    exc_req = 1'b0;
    #1;
    check_val("t2_exc_addr", redir_addr, 32'h8000_0200);
    count_flush(2, "t2_exc_flush");

    // Backpressure with an interrupt arriving during the wait
    ifu_ready = 1'b0; bru_req = 1'b1; bru_addr = 32'h0000_0040;
    #1;
    check_val("t3_ack", acks(), 32'b001);
    sb_q.push_back({2'd1, 32'h0000_0040});
    cyc();
    bru_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      if (i == 2) begin
        int_req = 1'b1; int_addr = 32'h0000_0901;
      end
      #1;
      check_val("t3_wait_valid", {31'b0, redir_valid}, 1);
      check_val("t3_wait_addr", redir_addr, 32'h0000_0040);
      check_val("t3_wait_ack", acks(), 0);
    end
    cyc();
    ifu_ready = 1'b1;
    #1;
    check_val("t3_hs_addr", redir_addr, 32'h0000_0040);
    check_val("t3_hs_ack", acks(), 0);
    count_flush(2, "t3_flush");
    check_val("t3_int_ack", acks(), 32'b100);
    sb_q.push_back({2'd3, 32'h0000_0900});
    cyc();
    int_req = 1'b0;
    #1;
    check_val("t3_int_src", {30'b0, redir_src}, 3);
    count_flush(2, "t3_int_flush");

    // Reset during REDIR, then during FLUSH
    ifu_ready = 1'b0; bru_req = 1'b1; bru_addr = 32'h0000_2000;
    #1;
    check_val("t4_ack", acks(), 32'b001);
    cyc();
    bru_req = 1'b0; rst_n = 1'b0;
    #1;
    check_val("t4_redir", {31'b0, redir_valid}, 1);
    cyc();
    rst_n = 1'b1;
    #1;
    check_val("t4_rst_valid", {31'b0, redir_valid}, 0);
    check_val("t4_rst_addr", redir_addr, 0);
    check_val("t4_rst_misc", {29'b0, redir_src, flush, hold}, 0);
    bru_req = 1'b1; bru_addr = 32'h0000_3001; ifu_ready = 1'b1;
    #1;
    check_val("t4_post_ack", acks(), 32'b001);
    sb_q.push_back({2'd1, 32'h0000_3000});
    cyc();
    bru_req = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    check_val("t4_in_flush", {31'b0, flush}, 1);
    cyc();
    rst_n = 1'b1;
    #1;
    check_val("t4_rst2", {28'b0, redir_valid, redir_src, flush}, 0);
    check_val("t4_rst2_hold", {31'b0, hold}, 0);
    bru_req = 1'b1; bru_addr = 32'h0000_3100;
    #1;
    check_val("t4_post2_ack", acks(), 32'b001);
    sb_q.push_back({2'd1, 32'h0000_3100});
    cyc();
    bru_req = 1'b0;
    count_flush(2, "t4_flush");

    // Branch request pulsed during FLUSH is lost
    bru_req = 1'b1; bru_addr = 32'h0000_4000;
    #1;
    check_val("t5_ack", acks(), 32'b001);
    sb_q.push_back({2'd1, 32'h0000_4000});
    cyc();
    bru_req = 1'b0;
    cyc();
    bru_req = 1'b1; bru_addr = 32'h0000_5000;
    #1;
    check_val("t5_drop_ack", acks(), 0);
    check_val("t5_drop_hold", {30'b0, hold, flush}, 32'b11);
    cyc();
    bru_req = 1'b0;
    #1;
    check_val("t5_flush2", {31'b0, flush}, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      check_val("t5_quiet", {29'b0, redir_valid, flush, hold}, 0);
      check_val("t5_quiet_ack", acks(), 0);
    end

    // Flush length for FLUSH_CYCLES = 1 and 15, request held throughout
    breq_f = 1'b1; baddr_f = 32'h0000_0077;
    #1;
    check_val("t6_ack", {30'b0, ack1_bru, ack15_bru}, 32'b11);
    cyc();
    #1;
    check_val("t6_valid", {30'b0, val1, val15}, 32'b11);
    check_val("t6_addr", addr15, 32'h0000_0076);
    n1 = 0; n15 = 0; d1 = 1'b0; d15 = 1'b0; f_acks = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      #1;
      if (!d1) begin
        if (flush1) begin
          n1++;
          f_acks = f_acks | ack1_bru | ack1_int | ack1_exc;
        end else if (n1 > 0) d1 = 1'b1;
      end
      if (!d15) begin
        if (flush15) begin
          n15++;
          f_acks = f_acks | ack15_bru | ack15_int | ack15_exc;
        end else if (n15 > 0) d15 = 1'b1;
      end
    end
    check_val("t6_flush1", n1, 1);
    check_val("t6_flush15", n15, 15);
    check_val("t6_flush_acks", {31'b0, f_acks}, 0);
    breq_f = 1'b0;

    repeat (3) cyc();
    check_val("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_redirect_ctrl.md
Name: exu_redirect_ctrl

Overview:
- Sequences every PC redirect leaving the execute stage.
- Arbitrates redirect requests from three sources: interrupt/trap logic, CSR return/exception logic, and the branch unit (taken branch, JAL/JALR, FENCE).
- Registers the winning target and hands it to the IFU over a valid/ready handshake.
- After the IFU accepts, drives a fixed-length pipeline flush before the next redirect is accepted.

Parameters:
ADDR_W, 32, redirect address width (matches `INST_ADDR_WIDTH).
FLUSH_CYCLES, 2, cycles flush_o stays high after IFU acceptance; legal range 1..15.

Ports:
clk  input  1  core clock.
rst_n  input  1  synchronous reset, active low.
int_req_i  input  1  interrupt/trap redirect request; held until int_ack_o.
int_addr_i  input  ADDR_W  interrupt/trap target.
exc_req_i  input  1  CSR redirect request (mret, ecall, ebreak); held until exc_ack_o.
exc_addr_i  input  ADDR_W  CSR redirect target.
bru_req_i  input  1  branch-unit jump flag.
bru_addr_i  input  ADDR_W  branch-unit jump target.
int_ack_o  output  1  interrupt request accepted this cycle.
exc_ack_o  output  1  CSR request accepted this cycle.
bru_ack_o  output  1  branch request accepted this cycle.
redir_valid_o  output  1  redirect pending to IFU.
redir_addr_o  output  ADDR_W  redirect target; zero when redir_valid_o=0.
redir_src_o  output  2  source of pending redirect: 0 none, 1 bru, 2 exc, 3 int.
ifu_ready_i  input  1  IFU accepts redirect.
flush_o  output  1  kill IF/ID/EX contents.
hold_o  output  1  stall fetch/decode issue.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, flush counter 0, captured address 0, captured source 0.
- Output values in reset: acks 0, redir_valid_o 0, redir_addr_o 0, redir_src_o 0, flush_o 0, hold_o 0.
- Reset mid-operation abandons any pending redirect or flush immediately; no ack is reissued.
- States:
  - IDLE: no redirect pending.
  - REDIR: redir_valid_o=1, waiting for ifu_ready_i.
  - FLUSH: counting down the flush window.
- IDLE:
  - Fixed priority int > exc > bru.
  - If any request is high, the highest-priority source gets a combinational ack in the same cycle.
  - Its address is captured with bit 0 forced to 0, source is recorded, and the next state is REDIR.
  - Lower-priority simultaneous requests are not acked. Their requesters hold the request; a branch request is normally killed by the following flush.
- REDIR:
  - redir_valid_o=1; redir_addr_o and redir_src_o are stable, from registers.
  - No acks in this state; no preemption, even by int_req_i.
  - When ifu_ready_i=1, the handshake completes that cycle. Next state is FLUSH with counter loaded to FLUSH_CYCLES-1.
  - redir_valid_o may stay high for any number of cycles; no timeout.
- FLUSH:
  - flush_o=1 and no acks.
  - Counter decrements each cycle; when counter==0, next state is IDLE.
  - flush_o is high for exactly FLUSH_CYCLES cycles, starting the cycle after the handshake.
  - Captured source clears to 0 on exit.
- hold_o = (state!=IDLE) | int_req_i | exc_req_i | bru_req_i.
  - Decode is therefore stalled from the request cycle until IDLE is re-entered.
- flush_o is registered (state-decoded); acks are combinational from requests and state only, with no path from ifu_ready_i.
- Throughput:
  - Minimum spacing between two acks is 2 + FLUSH_CYCLES cycles (ack, REDIR with immediate ready, FLUSH_CYCLES).
  - Back-to-back: a request present in the cycle IDLE is re-entered is acked in that cycle.
- Requests that drop before being acked are simply lost; no internal request storage.
- Widths: address passes through unmodified except for bit 0; no arithmetic on addresses.

Test Plan:
- Single branch:
  - Stimulus: bru_req_i=1 with addr 0x0000_1235 for one cycle in IDLE, ifu_ready_i=1.
  - Required: bru_ack_o=1 same cycle; next cycle redir_valid_o=1, addr 0x0000_1234, src 1.
  - Then flush_o high for exactly 2 cycles, then IDLE with hold_o=0.
- Priority:
  - Stimulus: int_req_i (0x8000_0100), exc_req_i (0x8000_0200) and bru_req_i (0x100) all asserted together.
  - Required: only int_ack_o; redirect to 0x8000_0100, src 3.
  - exc held high is acked first cycle back in IDLE, redirect to 0x8000_0200.
- Backpressure:
  - Stimulus: ifu_ready_i=0 for 5 cycles after a bru accept to 0x40; int_req_i raised during the wait.
  - Required: redir_valid_o/addr stable 0x40 throughout, no int_ack_o until after flush completes, then int redirect.
- Flush length:
  - Stimulus: instantiate FLUSH_CYCLES=1 and FLUSH_CYCLES=15.
  - Required: flush_o high exactly 1 and 15 cycles respectively; acks suppressed throughout.
- Reset mid-op:
  - Stimulus: rst_n=0 during REDIR, then during FLUSH (counter 1).
  - Required: next cycle all outputs 0, state IDLE; after release, a new bru request is acked immediately.
- Dropped request:
  - Stimulus: bru_req_i pulses for 1 cycle during FLUSH.
  - Required: no bru_ack_o and no later redirect; hold_o high in that cycle only due to state.
